// File: rtl/control_fsm_p_pkg.sv
// Shared definitions for the control_fsm_p CPU controller: state encoding,
// instruction opcodes, the wait-counter width and debug string helpers.
package control_fsm_p_pkg;

    // Wide enough for LOAD_WAIT in 0..15.
    localparam int WAIT_W = 4;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_JPZ    = 4'd10,
        ST_TRAP   = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        _noop  = 4'd0,
        _store = 4'd1,
        _load  = 4'd2,
        _add   = 4'd3,
        _sub   = 4'd4,
        _halt  = 4'd5,
        _jpz   = 4'd6
    } inst_t;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    function automatic string state_to_string(input state_t s);
        case (s)
            ST_INIT:   return "Init";
            ST_FETCH:  return "Fetch";
            ST_DECODE: return "Decode";
            ST_NOOP:   return "Noop";
            ST_STORE:  return "Store";
            ST_LOAD_A: return "Load_A";
            ST_LOAD_B: return "Load_B";
            ST_ADD:    return "Add";
            ST_SUB:    return "Sub";
            ST_HALT:   return "Halt";
            ST_JPZ:    return "Jpz";
            ST_TRAP:   return "Trap";
            default:   return "Unknown";
        endcase
    endfunction

    function automatic string inst_to_string(input inst_t i);
        case (i)
            _noop:   return "noop";
            _store:  return "store";
            _load:   return "load";
            _add:    return "add";
            _sub:    return "sub";
            _halt:   return "halt";
            _jpz:    return "jpz";
            default: return "undef";
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_p_wait_counter.sv
// Loadable down-counter with zero flag. Saturates at zero so a stray
// decrement never wraps into a long wait.
module control_fsm_p_wait_counter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load takes priority over decrement; synchronous clear on Reset.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && (r_cnt != '0))
            r_cnt <= r_cnt - W'(1);
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/control_fsm_p.sv
// CPU control state machine: decodes IR and drives the datapath controls.
// Optional macro CONTROL_FSM_ILLEGAL_TRAP_EN: undefined opcodes enter a
// Trap state (Illegal=1) that only Reset leaves; otherwise they act as Noop.
//
// state   | meaning
// Init    | clear PC
// Fetch   | increment PC, load IR
// Decode  | opcode dispatch
// Noop    | no operation
// Store   | write reg A to mem[{B,C}]
// Load_A  | address mem[{A,B}], hold LOAD_WAIT+1 cycles
// Load_B  | write read data into reg C
// Add/Sub | C <= A op B
// Jpz     | relative jump by {B,C} when reg A is zero
// Halt    | idle until Resume
// Trap    | illegal opcode, idle until Reset (macro only)
module control_fsm_p
    import control_fsm_p_pkg::*;
#(
    parameter  int RA_W      = 4,
    parameter  int OP_W      = 4,
    parameter  int ALU_W     = 3,
    parameter  int LOAD_WAIT = 0,
    localparam int IW        = OP_W + 3*RA_W,
    localparam int DA_W      = 2*RA_W
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [IW-1:0]   IR,
    input  logic            Ra_zero,
    input  logic            Resume,
    output logic            D_wr,
    output logic            RF_s,
    output logic            RF_W_en,
    output logic            PC_clr,
    output logic            IR_ld,
    output logic            PC_up,
    output logic            PC_ld,
    output logic [DA_W-1:0] PC_off,
    output logic [DA_W-1:0] D_addr,
    output logic [RA_W-1:0] RF_W_addr,
    output logic [RA_W-1:0] RF_Ra_addr,
    output logic [RA_W-1:0] RF_Rb_addr,
    output logic [ALU_W-1:0] Alu_s0,
    output logic            Illegal,
    output state_t          CurrentState,
    output state_t          NextState
);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] w_op;
    logic [RA_W-1:0] w_a, w_b, w_c;
    logic            w_wait_zero;
    logic            w_wait_load;
    logic            w_wait_dec;

    assign w_op = IR[IW-1 -: OP_W];
    assign w_a  = IR[3*RA_W-1 : 2*RA_W];
    assign w_b  = IR[2*RA_W-1 : RA_W];
    assign w_c  = IR[RA_W-1 : 0];

    // Counter is armed on the Decode->Load_A transition and runs down in Load_A.
    assign w_wait_load = (r_state == ST_DECODE) && (w_next == ST_LOAD_A);
    assign w_wait_dec  = (r_state == ST_LOAD_A);

    control_fsm_p_wait_counter #(.W(WAIT_W)) u_wait (
        .Clk    (Clk),
        .Reset  (Reset),
        .i_load (w_wait_load),
        .i_val  (WAIT_W'(LOAD_WAIT)),
        .i_dec  (w_wait_dec),
        .o_zero (w_wait_zero)
    );

    // State register with synchronous reset; Reset overrides Resume.
    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= ST_INIT;
        else
            r_state <= w_next;
    end

    // Next-state decode and combinational datapath controls.
    always_comb begin
        w_next     = ST_INIT;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_en    = 1'b0;
        PC_clr     = 1'b0;
        IR_ld      = 1'b0;
        PC_up      = 1'b0;
        PC_ld      = 1'b0;
        PC_off     = '0;
        D_addr     = '0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        Alu_s0     = '0;
        Illegal    = 1'b0;
        case (r_state)
            ST_INIT: begin
                PC_clr = 1'b1;
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                PC_up  = 1'b1;
                IR_ld  = 1'b1;
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (w_op)
                    OP_W'(_noop):  w_next = ST_NOOP;
                    OP_W'(_store): w_next = ST_STORE;
                    OP_W'(_load):  w_next = ST_LOAD_A;
                    OP_W'(_add):   w_next = ST_ADD;
                    OP_W'(_sub):   w_next = ST_SUB;
                    OP_W'(_halt):  w_next = ST_HALT;
                    OP_W'(_jpz):   w_next = ST_JPZ;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
                    default:       w_next = ST_TRAP;
`else
                    default:       w_next = ST_NOOP;
`endif
                endcase
            end
            ST_NOOP: w_next = ST_FETCH;
            ST_STORE: begin
                D_addr     = {w_b, w_c};
                D_wr       = 1'b1;
                RF_Ra_addr = w_a;
                w_next     = ST_FETCH;
            end
            ST_LOAD_A: begin
                D_addr    = {w_a, w_b};
                RF_s      = 1'b1;
                RF_W_addr = w_c;
                w_next    = w_wait_zero ? ST_LOAD_B : ST_LOAD_A;
            end
            ST_LOAD_B: begin
                D_addr    = {w_a, w_b};
                RF_s      = 1'b1;
                RF_W_addr = w_c;
                RF_W_en   = 1'b1;
                w_next    = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = w_a;
                RF_Rb_addr = w_b;
                RF_W_addr  = w_c;
                RF_W_en    = 1'b1;
                Alu_s0     = (r_state == ST_ADD) ? ALU_W'(ALU_ADD) : ALU_W'(ALU_SUB);
                w_next     = ST_FETCH;
            end
            ST_JPZ: begin
                RF_Ra_addr = w_a;
                if (Ra_zero) begin
                    PC_ld  = 1'b1;
                    PC_off = {w_b, w_c};
                end
                w_next = ST_FETCH;
            end
            ST_HALT: w_next = Resume ? ST_FETCH : ST_HALT;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                Illegal = 1'b1;
                w_next  = ST_TRAP;
            end
`endif
            default: w_next = ST_INIT;
        endcase
    end

    assign CurrentState = r_state;
    assign NextState    = w_next;

endmodule

// File: tb/tb_control_fsm_p.sv
// Randomized self-checking bench for control_fsm_p (LOAD_WAIT=2).
module tb_control_fsm_p;
    import control_fsm_p_pkg::*;

    localparam int LW = 2;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif
    localparam int PH_INIT = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_LOADB = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] IR = '0;
    logic        Ra_zero = 1'b0;
    logic        Resume = 1'b0;
    logic        D_wr, RF_s, RF_W_en, PC_clr, IR_ld, PC_up, PC_ld, Illegal;
    logic [7:0]  PC_off, D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
    logic [2:0]  Alu_s0;
    state_t      CurrentState, NextState;
    logic [38:0] w_obs;

    int n_tot = 0;
    int n_bad = 0;

    control_fsm_p #(.RA_W(4), .OP_W(4), .ALU_W(3), .LOAD_WAIT(LW)) dut (
        .Clk(Clk), .Reset(Reset), .IR(IR), .Ra_zero(Ra_zero), .Resume(Resume),
        .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .PC_clr(PC_clr),
        .IR_ld(IR_ld), .PC_up(PC_up), .PC_ld(PC_ld), .PC_off(PC_off),
        .D_addr(D_addr), .RF_W_addr(RF_W_addr), .RF_Ra_addr(RF_Ra_addr),
        .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0), .Illegal(Illegal),
        .CurrentState(CurrentState), .NextState(NextState)
    );

    always #5 Clk = ~Clk;

    assign w_obs = {D_wr, RF_s, RF_W_en, PC_clr, IR_ld, PC_up, PC_ld, PC_off,
                    D_addr, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0, Illegal};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected control word from the instruction-level rules.
    function automatic logic [38:0] model_out(input int ph, input logic [15:0] ir, input logic rz);
        logic d_wr, rf_s, we, pc_clr, ir_ld, pc_up, pc_ld, ill;
        logic [7:0] pc_off, d_addr;
        logic [3:0] w, ra, rb, op, a, b, c;
        logic [2:0] alu;
        {d_wr, rf_s, we, pc_clr, ir_ld, pc_up, pc_ld, ill} = '0;
        pc_off = '0; d_addr = '0; w = '0; ra = '0; rb = '0; alu = '0;
        op = ir[15:12]; a = ir[11:8]; b = ir[7:4]; c = ir[3:0];
        case (ph)
            PH_INIT:  pc_clr = 1'b1;
            PH_FETCH: begin pc_up = 1'b1; ir_ld = 1'b1; end
            PH_EXEC: begin
                if (op == 1) begin d_addr = {b, c}; d_wr = 1'b1; ra = a; end
                else if (op == 2) begin d_addr = {a, b}; rf_s = 1'b1; w = c; end
                else if (op == 3 || op == 4) begin
                    ra = a; rb = b; w = c; we = 1'b1; alu = (op == 3) ? 3'd1 : 3'd2;
                end
                else if (op == 6) begin
                    ra = a;
                    if (rz) begin pc_ld = 1'b1; pc_off = {b, c}; end
                end
                else if (op > 6) ill = TRAP_ON;
            end
            PH_LOADB: begin d_addr = {a, b}; rf_s = 1'b1; w = c; we = 1'b1; end
            default: ;
        endcase
        return {d_wr, rf_s, we, pc_clr, ir_ld, pc_up, pc_ld, pc_off, d_addr, w, ra, rb, alu, ill};
    endfunction

    function automatic state_t exec_state(input logic [3:0] op);
        case (op)
            4'd0: return ST_NOOP;
            4'd1: return ST_STORE;
            4'd2: return ST_LOAD_A;
            4'd3: return ST_ADD;
            4'd4: return ST_SUB;
            4'd5: return ST_HALT;
            4'd6: return ST_JPZ;
            default: return TRAP_ON ? ST_TRAP : ST_NOOP;
        endcase
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Holds reset two cycles, releases it and leaves the FSM sampled in Fetch.
    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #1;
        chk("init_state", 64'(CurrentState), 64'(ST_INIT));
        chk("init_out", 64'(w_obs), 64'(model_out(PH_INIT, IR, Ra_zero)));
        chk("init_next", 64'(NextState), 64'(ST_FETCH));
        step();
    endtask

    // Runs one instruction starting in Fetch and ends back in Fetch.
    task automatic run_instr(input logic [15:0] ir, input logic rz, input int halt_hold);
        state_t es;
        IR = ir; Ra_zero = rz; Resume = 1'b0;
        #1;
        chk("fetch_state", 64'(CurrentState), 64'(ST_FETCH));
        chk("fetch_out", 64'(w_obs), 64'(model_out(PH_FETCH, ir, rz)));
        step();
        es = exec_state(ir[15:12]);
        chk("decode_state", 64'(CurrentState), 64'(ST_DECODE));
        chk("decode_out", 64'(w_obs), 64'(model_out(PH_DECODE, ir, rz)));
        chk("decode_next", 64'(NextState), 64'(es));
        step();
        if (es == ST_LOAD_A) begin
            for (int i = 0; i <= LW; i++) begin
                chk("loada_state", 64'(CurrentState), 64'(ST_LOAD_A));
                chk("loada_out", 64'(w_obs), 64'(model_out(PH_EXEC, ir, rz)));
                step();
            end
            chk("loadb_state", 64'(CurrentState), 64'(ST_LOAD_B));
            chk("loadb_out", 64'(w_obs), 64'(model_out(PH_LOADB, ir, rz)));
            step();
        end else if (es == ST_HALT) begin
            for (int i = 0; i < halt_hold; i++) begin
                chk("halt_state", 64'(CurrentState), 64'(ST_HALT));
                chk("halt_out", 64'(w_obs), 64'(model_out(PH_EXEC, ir, rz)));
                step();
            end
            Resume = 1'b1;
            #1;
            chk("halt_resume_next", 64'(NextState), 64'(ST_FETCH));
            step();
            Resume = 1'b0;
        end else if (es == ST_TRAP) begin
            Resume = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk("trap_state", 64'(CurrentState), 64'(ST_TRAP));
                chk("trap_out", 64'(w_obs), 64'(model_out(PH_EXEC, ir, rz)));
                step();
            end
            Resume = 1'b0;
            do_reset();
        end else begin
            chk("exec_state", 64'(CurrentState), 64'(es));
            chk("exec_out", 64'(w_obs), 64'(model_out(PH_EXEC, ir, rz)));
            step();
        end
        #1;
        chk("back_to_fetch", 64'(CurrentState), 64'(ST_FETCH));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        #2;
        do_reset();

        run_instr(16'h3123, 1'b0, 0);
        run_instr(16'h4567, 1'b0, 0);
        run_instr(16'h2AB5, 1'b0, 0);
        run_instr(16'h1C3D, 1'b1, 0);
        run_instr(16'h61FE, 1'b1, 0);
        run_instr(16'h61FE, 1'b0, 0);
        run_instr(16'h6300, 1'b1, 0);
        run_instr(16'h62FF, 1'b1, 0);
        run_instr(16'h5000, 1'b0, 10);
        run_instr(16'hF000, 1'b1, 0);
        run_instr(16'h0000, 1'b0, 0);

        // Resume and Reset together in Halt: Reset wins.
        IR = 16'h5000; Resume = 1'b0;
        step(); step();
        chk("halt_entry", 64'(CurrentState), 64'(ST_HALT));
        Resume = 1'b1; Reset = 1'b1;
        step();
        chk("reset_over_resume", 64'(CurrentState), 64'(ST_INIT));
        Resume = 1'b0;
        step();
        Reset = 1'b0;
        step();

        // Reset during Load_A wait: Init next edge, no write enable ever.
        IR = 16'h2AB5;
        #1;
        chk("mid_fetch", 64'(CurrentState), 64'(ST_FETCH));
        step(); step();
        chk("mid_loada", 64'(CurrentState), 64'(ST_LOAD_A));
        chk("mid_we0", 64'(RF_W_en), 64'(0));
        step();
        chk("mid_loada2", 64'(CurrentState), 64'(ST_LOAD_A));
        Reset = 1'b1;
        #1;
        chk("mid_we1", 64'(RF_W_en), 64'(0));
        step();
        chk("mid_init", 64'(CurrentState), 64'(ST_INIT));
        chk("mid_we2", 64'(RF_W_en), 64'(0));
        Reset = 1'b0;
        step();

        for (int n = 0; n < 60; n++) begin
            logic [15:0] r_ir;
            r_ir = 16'($urandom);
            if (n % 4 == 0) r_ir[15:12] = 4'($urandom_range(0, 6));
            run_instr(r_ir, 1'($urandom_range(0, 1)), int'($urandom_range(1, 5)));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/control_fsm_p.md
Name: control_fsm_p

Overview:
- Parametrised successor of the CPU control state machine. Decodes the 16-bit-class instruction held in IR and drives PC, IR, data memory, register file and ALU control lines.
- Adds three capabilities: configurable memory-read wait states, a conditional relative jump (JPZ), and a Resume exit from Halt.
- Sits inside the control unit, between the instruction register and the datapath.
- CurrentState/NextState are exported for debug and display.

Parameters:
- RA_W, 4: register-address field width. Instruction width IW = OP_W + 3*RA_W (localparam). Data-address width DA_W = 2*RA_W (localparam).
- OP_W, 4: opcode field width, taken from IR[IW-1 -: OP_W].
- ALU_W, 3: ALU select width.
- LOAD_WAIT, 0: extra cycles Load_A holds before Load_B, for registered-output RAM. Range 0..15.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- IR  in  IW  current instruction. Fields: A=IR[3RA_W-1:2RA_W], B=IR[2RA_W-1:RA_W], C=IR[RA_W-1:0].
- Ra_zero  in  1  register-file read port A value == 0 (same-cycle combinational).
- Resume  in  1  leave Halt.
- D_wr, RF_s, RF_W_en, PC_clr, IR_ld, PC_up, PC_ld  out  1 each  datapath controls.
- PC_off  out  DA_W  signed PC offset, valid when PC_ld=1.
- D_addr  out  DA_W  data memory address.
- RF_W_addr, RF_Ra_addr, RF_Rb_addr  out  RA_W each  register addresses.
- Alu_s0  out  ALU_W  ALU function select.
- Illegal  out  1  trap flag (only with the optional feature; otherwise tied 0).
- CurrentState, NextState  out  State  debug.

Behaviour:
- Reset=1 at a rising edge: CurrentState <= Init, wait counter <= 0. This holds in any state, including mid-Load.
- Outputs are combinational from state and IR. Every output defaults to 0 unless listed below.
- Init: PC_clr=1 -> Fetch.
- Fetch: PC_up=1, IR_ld=1 -> Decode.
- Decode: opcode dispatch.
  - 0 -> Noop
  - 1 -> Store
  - 2 -> Load_A
  - 3 -> Add
  - 4 -> Sub
  - 5 -> Halt
  - 6 -> Jpz
  - others -> Noop
- Noop: -> Fetch.
- Store: D_addr={B,C}, D_wr=1, RF_Ra_addr=A -> Fetch.
- Load_A: D_addr={A,B}, RF_s=1, RF_W_addr=C.
  - Wait counter loads LOAD_WAIT on entry and decrements each cycle.
  - Go to Load_B when counter==0. Load_A therefore lasts LOAD_WAIT+1 cycles.
- Load_B: same outputs as Load_A plus RF_W_en=1 -> Fetch.
- Add/Sub: RF_Ra_addr=A, RF_Rb_addr=B, RF_W_addr=C, RF_W_en=1, RF_s=0; Alu_s0=1 (Add) or 2 (Sub) -> Fetch.
- Jpz: RF_Ra_addr=A. If Ra_zero=1: PC_ld=1, PC_off={B,C}, sign-extended by the PC. -> Fetch.
  - PC already points past the JPZ, so offset 0 is a fall-through.
  - Offset 8'hFF loops back onto the JPZ itself.
- Halt: outputs idle. Resume=1 -> Fetch; otherwise stay. Resume is ignored in every other state.
- Undefined state encoding -> Init.
- Instruction latency in cycles, including Fetch and Decode:
  - Noop/Store/Add/Sub/Jpz: 3
  - Load: 4+LOAD_WAIT
- Reset and Resume asserted together: Reset wins.

Optional Feature:
- Macro: CONTROL_FSM_ILLEGAL_TRAP_EN.
- Defined: undefined opcodes go from Decode to Trap. Trap asserts Illegal=1, all other outputs are 0, and it is left only via Reset; Resume has no effect.
- Undefined: undefined opcodes execute as Noop, Trap does not exist, Illegal is constant 0.

Decomposition:
- Package StateDefs is extended:
  - State enum gains Jpz and Trap.
  - inst enum gains _jpz=6.
  - state_to_string/inst_to_string cover the new values.
  - Opcode constants live there.
- One sub-module, wait_counter (loadable down-counter: load, dec, zero flag). It is also reusable for future multi-cycle ALU ops.

Test Plan:
- Reset=1 for 2 cycles, then release -> Init with PC_clr=1. Sequence is Fetch, Decode at the next edges.
- IR=16'h3123 (Add) -> Add state with Ra=1, Rb=2, W=3, Alu_s0=1, RF_W_en=1. Back in Fetch 3 cycles after the previous Fetch.
- LOAD_WAIT=2, IR=16'h2AB5 -> Load_A for 3 cycles (D_addr=8'hAB, RF_W_addr=5, RF_W_en=0), then Load_B for 1 cycle with RF_W_en=1.
- IR=16'h61FE:
  - Ra_zero=1 -> PC_ld=1, PC_off=8'hFE.
  - Ra_zero=0 -> PC_ld=0. Both cases -> Fetch.
- IR=16'h5000 -> Halt held for 10 cycles with Resume=0. Resume=1 -> Fetch next edge. Resume and Reset together -> Init.
- IR=16'hF000:
  - With the macro: Trap, Illegal=1, persists until Reset.
  - Without the macro: Noop -> Fetch.
- Reset asserted in Load_A mid-wait: Init next edge; RF_W_en never pulses.
